// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, block/round-index types, S-box table
// and GF(2^8) helpers (polynomial x^8+x^4+x^3+x+1).
package aes_pkg;

  localparam int AES_NR       = 14;
  localparam int AES_NK_WORDS = 8;

  // Block vector: bit 0 is the MSB, byte n occupies bits 8n..8n+7.
  typedef logic [0:127] aes_block_t;
  typedef logic [3:0]   aes_ridx_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x: shift left, reduce with 0x1b when bit 7 falls out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply; with a constant operand it folds to a few XORs.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes256_enc_iter_if.sv
// Plaintext-in / ciphertext-out valid/ready bus of the iterative AES-256
// encryptor. The encryptor is the slave; the producer/consumer side is master.
interface aes256_enc_iter_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_block_t in_data;
  logic       out_valid;
  logic       out_ready;
  aes_block_t out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped when final_i is set) and AddRoundKey. State is column-major:
// byte index = 4*column + row.
module aes_round import aes_pkg::*; (
  input  aes_block_t state_i,
  input  aes_block_t rk_i,
  input  logic       final_i,
  output aes_block_t state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Substitute, rotate row r left by r columns, mix each column, add key.
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      sb[n] = SBOX[state_i[8*n +: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c + 0] = xtime(sr[4*c + 0]) ^ gmul(sr[4*c + 1], 8'h03) ^ sr[4*c + 2] ^ sr[4*c + 3];
      mc[4*c + 1] = sr[4*c + 0] ^ xtime(sr[4*c + 1]) ^ gmul(sr[4*c + 2], 8'h03) ^ sr[4*c + 3];
      mc[4*c + 2] = sr[4*c + 0] ^ sr[4*c + 1] ^ xtime(sr[4*c + 2]) ^ gmul(sr[4*c + 3], 8'h03);
      mc[4*c + 3] = gmul(sr[4*c + 0], 8'h03) ^ sr[4*c + 1] ^ sr[4*c + 2] ^ xtime(sr[4*c + 3]);
    end
    for (int n = 0; n < 16; n++) begin
      state_o[8*n +: 8] = (final_i ? sr[n] : mc[n]) ^ rk_i[8*n +: 8];
    end
  end

endmodule

// File: rtl/aes256_enc_iter.sv
// Iterative AES-256 encryptor: one round per clock using round keys fetched
// through rk_idx/rk_in from an external 15-way key mux.
// Optional feature macro: AES_ENC_ABORT_EN adds an abort input that drops an
// in-flight or completed block and returns to IDLE.
module aes256_enc_iter import aes_pkg::*; #(
  parameter int NR = AES_NR
) (
  input  logic             clk,
  input  logic             rst_n,
  aes256_enc_iter_if.slave bus,
  output aes_ridx_t        rk_idx,
`ifdef AES_ENC_ABORT_EN
  input  logic             abort,
`endif
  input  aes_block_t       rk_in
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e       state_q, state_d;
  aes_ridx_t  cnt_q, cnt_d;
  aes_block_t data_q, data_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  aes_block_t round_out;
  logic       abort_w;

`ifdef AES_ENC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  aes_round u_round (
    .state_i (data_q),
    .rk_i    (rk_in),
    .final_i (cnt_q == 4'(NR)),
    .state_o (round_out)
  );

  // Next-state logic: accept, iterate rounds, hold result until drained.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a latch behind.
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q && !abort_w) begin
          data_d     = bus.in_data ^ rk_in;
          cnt_d      = 4'd1;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        data_d = round_out;
        if (cnt_q == 4'(NR)) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cnt_d       = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
    // Abort wins over everything once a block is in flight or waiting.
    if (abort_w && state_q != IDLE) begin
      data_d      = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      state_d     = IDLE;
    end
  end

  // State, counter, data and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      // NOTE: the data register is reset because it is also out_data.
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rk_idx        = cnt_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_aes256_enc_iter.sv
// Directed bench for aes256_enc_iter: known-answer vectors, latency and
// rk_idx sequence, backpressure, async reset mid-block, back-to-back blocks
// against an independent software AES, and abort when AES_ENC_ABORT_EN is set.
module tb_aes256_enc_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes256_enc_iter_if bus ();
  logic [3:0]   rk_idx;
  logic [0:127] rk_in;
  logic [0:127] rk_tbl [16];
`ifdef AES_ENC_ABORT_EN
  logic abort;
`endif

  assign rk_in = rk_tbl[rk_idx];

  aes256_enc_iter #(.NR(14)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .rk_idx (rk_idx),
`ifdef AES_ENC_ABORT_EN
    .abort  (abort),
`endif
    .rk_in  (rk_in)
  );

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int last_acc = -1;
  logic [7:0] m_sbox [256];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    check(tag, {127'd0, obs}, {127'd0, exp});
  endtask

  task automatic check_n(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    check(tag, {124'd0, obs}, {124'd0, exp});
  endtask

  // ---------------- independent software AES model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  // S-box from multiplicative inverse plus affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
  endfunction

  task automatic expand_key(input logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = m_mul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_tbl[15] = '0;
  endtask

  function automatic logic [0:127] m_encrypt(input logic [0:127] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] res;
    for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ rk_tbl[0][8*n +: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int n = 0; n < 16; n++) t[n] = m_sbox[s[n]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[rw + 4*c] = t[rw + 4*((c + rw) % 4)];
      if (r != 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk_tbl[r][8*n +: 8];
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  // Offer pt and wait for acceptance; returns at the negedge after the acceptance
  // edge. ok reports whether acceptance happened within the budget.
  task automatic start_block(input string tag, input logic [0:127] pt,
                             input logic spacing, output logic ok);
    int k;
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    ok = bus.in_ready;
    check_b({tag, " accept"}, bus.in_ready, 1'b1);
    if (ok) begin
      if (spacing && last_acc >= 0) check({tag, " spacing"}, 128'(cyc - last_acc), 128'd16);
      last_acc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Full block with rk_idx sequence, latency and ciphertext checks; returns at
  // the negedge right after the final round edge (out_valid should be high).
  task automatic do_block(input string tag, input logic [0:127] pt,
                          input logic [0:127] exp, input logic b2b);
    logic ok;
    start_block(tag, pt, b2b, ok);
    if (ok) begin
      if (!b2b) bus.in_valid = 1'b0;
      for (int r = 1; r <= 14; r++) begin
        check_n($sformatf("%s rk_idx r%0d", tag, r), rk_idx, 4'(r));
        check_b($sformatf("%s out_valid low r%0d", tag, r), bus.out_valid, 1'b0);
        @(negedge clk);
      end
      check_b({tag, " out_valid"}, bus.out_valid, 1'b1);
      check({tag, " out_data"}, bus.out_data, exp);
      check_n({tag, " rk_idx done"}, rk_idx, 4'd0);
      check_b({tag, " in_ready done"}, bus.in_ready, 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [0:255] c3_key, sp_key;
    logic [0:127] c3_pt, c3_ct, sp_pt, sp_ct, pt2, ct2, rpt;
    logic ok;

    c3_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    c3_pt  = 128'h00112233445566778899aabbccddeeff;
    c3_ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
    sp_key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    sp_pt  = 128'h6bc1bee22e409f96e93d7e117393172a;
    sp_ct  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    pt2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    build_sbox();
    expand_key(c3_key);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef AES_ENC_ABORT_EN
    abort = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check_b("reset in_ready", bus.in_ready, 1'b1);
    check_b("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 128'd0);
    check_n("reset rk_idx", rk_idx, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.3, then drain with out_ready high
    do_block("c3", c3_pt, c3_ct, 1'b0);
    @(negedge clk);
    check_b("c3 drained out_valid", bus.out_valid, 1'b0);
    check_b("c3 drained in_ready", bus.in_ready, 1'b1);

    // SP800-38A ECB-AES256 block 1
    expand_key(sp_key);
    do_block("sp", sp_pt, sp_ct, 1'b0);
    @(negedge clk);

    // Backpressure: out_ready low 20 cycles, in_valid held high
    bus.out_ready = 1'b0;
    do_block("bp", sp_pt, sp_ct, 1'b0);
    ct2 = m_encrypt(pt2);
    bus.in_data  = pt2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_b($sformatf("bp hold out_valid %0d", i), bus.out_valid, 1'b1);
      check($sformatf("bp hold out_data %0d", i), bus.out_data, sp_ct);
      check_b($sformatf("bp hold in_ready %0d", i), bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_b("bp release out_valid", bus.out_valid, 1'b0);
    check_b("bp release in_ready", bus.in_ready, 1'b1);
    do_block("bp next", pt2, ct2, 1'b0);

    // Async reset at round 7, then a fresh C.3 block
    expand_key(c3_key);
    start_block("rst", c3_pt, 1'b0, ok);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_n("rst pre rk_idx", rk_idx, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    check_b("rst async in_ready", bus.in_ready, 1'b1);
    check_b("rst async out_valid", bus.out_valid, 1'b0);
    check_n("rst async rk_idx", rk_idx, 4'd0);
    check("rst async out_data", bus.out_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_block("rst c3", c3_pt, c3_ct, 1'b0);

    // Back-to-back random blocks, in_valid held, 16-clock spacing
    last_acc = -1;
    for (int i = 0; i < 8; i++) begin
      rpt = {$urandom, $urandom, $urandom, $urandom};
      do_block($sformatf("b2b%0d", i), rpt, m_encrypt(rpt), 1'b1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_b("b2b end in_ready", bus.in_ready, 1'b1);

`ifdef AES_ENC_ABORT_EN
    // Abort in IDLE blocks acceptance
    bus.in_data  = c3_pt;
    bus.in_valid = 1'b1;
    abort        = 1'b1;
    @(negedge clk);
    check_b("abort idle in_ready", bus.in_ready, 1'b1);
    check_n("abort idle rk_idx", rk_idx, 4'd0);
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    // Abort at round 5
    start_block("abort", c3_pt, 1'b0, ok);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_n("abort pre rk_idx", rk_idx, 4'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_b("abort out_valid", bus.out_valid, 1'b0);
    check_b("abort in_ready", bus.in_ready, 1'b1);
    check_n("abort rk_idx", rk_idx, 4'd0);
    check("abort out_data", bus.out_data, 128'd0);
    @(negedge clk);
    check_b("abort no out_valid", bus.out_valid, 1'b0);
    do_block("abort c3", c3_pt, c3_ct, 1'b0);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
